// File: rtl/miner_job_driver.sv
// Job driver for a hashing core: streams a latched 640-bit block header out as
// twenty 32-bit beats, then collects an eight-word hash back with framing checks.
module miner_job_driver #(
  parameter int C_M_AXIS_TDATA_WIDTH   = 32,
  parameter int C_S_AXIS_TDATA_WIDTH   = 32,
  parameter int NUMBER_OF_OUTPUT_WORDS = 20,
  parameter int NUMBER_OF_INPUT_WORDS  = 8
) (
  input  logic                                                   m00_axis_aclk,
  input  logic                                                   m00_axis_aresetn,
  input  logic                                                   start,
  input  logic [NUMBER_OF_OUTPUT_WORDS*C_M_AXIS_TDATA_WIDTH-1:0] header,
  output logic                                                   busy,
  output logic                                                   done,
  output logic                                                   err,
  output logic [NUMBER_OF_INPUT_WORDS*C_S_AXIS_TDATA_WIDTH-1:0]  result,
  output logic                                                   m00_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]                        m00_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]                      m00_axis_tstrb,
  output logic                                                   m00_axis_tlast,
  input  logic                                                   m00_axis_tready,
  input  logic                                                   s00_axis_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]                        s00_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]                      s00_axis_tstrb,
  input  logic                                                   s00_axis_tlast,
  output logic                                                   s00_axis_tready
);

  localparam int TXW = $clog2(NUMBER_OF_OUTPUT_WORDS);
  localparam int RXW = $clog2(NUMBER_OF_INPUT_WORDS);
  localparam logic [TXW-1:0] TX_LAST = TXW'(NUMBER_OF_OUTPUT_WORDS - 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(NUMBER_OF_INPUT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t state, state_nxt;

  logic [NUMBER_OF_OUTPUT_WORDS*C_M_AXIS_TDATA_WIDTH-1:0] hdr_q;
  logic [NUMBER_OF_INPUT_WORDS*C_S_AXIS_TDATA_WIDTH-1:0]  result_q;
  logic [TXW-1:0] tx_idx;
  logic [RXW-1:0] rx_idx;
  logic           err_q;
  logic           tx_hs, rx_hs, tx_last, rx_last;
  logic           unused_tstrb;

  assign unused_tstrb = ^s00_axis_tstrb;

  assign tx_hs   = (state == SEND) && m00_axis_tready;
  assign rx_hs   = (state == RECV) && s00_axis_tvalid;
  assign tx_last = (tx_idx == TX_LAST);
  assign rx_last = (rx_idx == RX_LAST);

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) state <= IDLE;
    else                   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SEND;
      SEND: if (tx_hs && tx_last) state_nxt = RECV;
      RECV: if (rx_hs && (rx_last || s00_axis_tlast)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      hdr_q    <= '0;
      result_q <= '0;
      tx_idx   <= '0;
      rx_idx   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          hdr_q  <= header;
          err_q  <= 1'b0;
          tx_idx <= '0;
          rx_idx <= '0;
        end
        SEND: if (tx_hs) begin
          if (tx_last) begin
            tx_idx   <= '0;
            result_q <= '0;
          end else begin
            tx_idx <= tx_idx + TXW'(1);
          end
        end
        RECV: if (rx_hs) begin
          for (int unsigned j = 0; j < NUMBER_OF_INPUT_WORDS; j++)
            if (rx_idx == RXW'(j))
              result_q[(NUMBER_OF_INPUT_WORDS-1-j)*C_S_AXIS_TDATA_WIDTH +: C_S_AXIS_TDATA_WIDTH] <= s00_axis_tdata;
          // A frame is good only if tlast lands exactly on the final word
          if (rx_last || s00_axis_tlast) begin
            rx_idx <= '0;
            err_q  <= !(rx_last && s00_axis_tlast);
          end else begin
            rx_idx <= rx_idx + RXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m00_axis_tdata = '0;
    for (int unsigned k = 0; k < NUMBER_OF_OUTPUT_WORDS; k++)
      if ((state == SEND) && (tx_idx == TXW'(k)))
        m00_axis_tdata = hdr_q[(NUMBER_OF_OUTPUT_WORDS-1-k)*C_M_AXIS_TDATA_WIDTH +: C_M_AXIS_TDATA_WIDTH];
  end

  assign m00_axis_tvalid = (state == SEND);
  assign m00_axis_tlast  = (state == SEND) && tx_last;
  assign m00_axis_tstrb  = '1;
  assign s00_axis_tready = (state == RECV);
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign err             = err_q;
  assign result          = result_q;

endmodule

// File: tb/tb_miner_job_driver.sv
// Directed bench for miner_job_driver: header streaming, result collection,
// framing errors, ignored restarts and asynchronous reset mid-job.
module tb_miner_job_driver;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [639:0] header;
  logic         busy, done, err;
  logic [255:0] result;
  logic         m_tvalid, m_tlast, m_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tstrb;
  logic         s_tvalid, s_tlast, s_tready;
  logic [31:0]  s_tdata;
  logic [3:0]   s_tstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  miner_job_driver #(
    .C_M_AXIS_TDATA_WIDTH(32),
    .C_S_AXIS_TDATA_WIDTH(32),
    .NUMBER_OF_OUTPUT_WORDS(20),
    .NUMBER_OF_INPUT_WORDS(8)
  ) dut (
    .m00_axis_aclk(clk),
    .m00_axis_aresetn(rst_n),
    .start(start),
    .header(header),
    .busy(busy),
    .done(done),
    .err(err),
    .result(result),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tdata(m_tdata),
    .m00_axis_tstrb(m_tstrb),
    .m00_axis_tlast(m_tlast),
    .m00_axis_tready(m_tready),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tdata(s_tdata),
    .s00_axis_tstrb(s_tstrb),
    .s00_axis_tlast(s_tlast),
    .s00_axis_tready(s_tready)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [639:0] make_hdr(input logic [31:0] base);
    logic [639:0] h;
    for (int k = 0; k < 20; k++) h[639-32*k -: 32] = base + 32'(k) + 32'd1;
    return h;
  endfunction

  function automatic logic [255:0] make_res(input int n);
    logic [255:0] r = '0;
    for (int j = 0; j < n; j++) r[255-32*j -: 32] = 32'hA0 + 32'(j);
    return r;
  endfunction

  // Called at a negedge; leaves the bench at the first negedge inside SEND.
  task automatic do_start(input logic [639:0] hdr);
    start  = 1'b1;
    header = hdr;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    header = ~hdr;
    check("start_busy", 256'(busy), 256'(1));
    check("start_err_clear", 256'(err), 256'(0));
    check("start_tvalid", 256'(m_tvalid), 256'(1));
  endtask

  task automatic send_phase(input logic [639:0] hdr, input bit stall, input bit junk_rx,
                            input int poke_at, input int abort_at);
    int k = 0;
    bit was_stall = 1'b0;
    bit poked = 1'b0;
    logic [31:0] held_d = '0;
    logic held_l = 1'b0;
    for (int c = 0; c < 400 && k < 20; c++) begin
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_tvalid", 256'(m_tvalid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_tdata", 256'(m_tdata), 256'(0));
        m_tready = 1'b0;
        return;
      end
      if (k == poke_at && !poked) begin
        start = 1'b1;
        header = make_hdr(32'hDEAD0000);
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      s_tvalid = junk_rx;
      s_tdata  = 32'hBADBAD00 + 32'(c);
      s_tlast  = junk_rx;
      m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      check("tx_tvalid", 256'(m_tvalid), 256'(1));
      check("tx_tstrb", 256'(m_tstrb), 256'(4'hF));
      check("tx_s_tready", 256'(s_tready), 256'(0));
      if (was_stall) begin
        check("stall_tdata", 256'(m_tdata), 256'(held_d));
        check("stall_tlast", 256'(m_tlast), 256'(held_l));
      end
      if (m_tready) begin
        check($sformatf("tx_word%0d", k), 256'(m_tdata), 256'(hdr[639-32*k -: 32]));
        check($sformatf("tx_tlast%0d", k), 256'(m_tlast), 256'(k == 19));
        k++;
        was_stall = 1'b0;
      end else begin
        was_stall = 1'b1;
        held_d = m_tdata;
        held_l = m_tlast;
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    m_tready = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("tx_beats", 256'(k), 256'(20));
    check("recv_tvalid_low", 256'(m_tvalid), 256'(0));
    check("recv_s_tready", 256'(s_tready), 256'(1));
    check("recv_result_cleared", result, 256'(0));
  endtask

  task automatic recv_phase(input int n, input int tlast_at, input bit ninth,
                            input logic [255:0] exp_res, input bit exp_err);
    for (int j = 0; j < n; j++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'hA0 + 32'(j);
      s_tlast  = (j == tlast_at);
      s_tstrb  = 4'h0;
      check($sformatf("rx_tready%0d", j), 256'(s_tready), 256'(1));
      @(posedge clk);
      @(negedge clk);
    end
    s_tvalid = ninth;
    s_tdata  = 32'hFFFFFFFF;
    s_tlast  = 1'b0;
    check("done_pulse", 256'(done), 256'(1));
    check("done_busy", 256'(busy), 256'(1));
    check("done_s_tready", 256'(s_tready), 256'(0));
    check("done_err", 256'(err), 256'(exp_err));
    check("done_result", result, exp_res);
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
    check("after_done", 256'(done), 256'(0));
    check("after_busy", 256'(busy), 256'(0));
    check("hold_err", 256'(err), 256'(exp_err));
    check("hold_result", result, exp_res);
    @(posedge clk);
    @(negedge clk);
    check("idle_hold_result", result, exp_res);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    header = '0;
    m_tready = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tstrb = '0;
    s_tlast = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_done", 256'(done), 256'(0));
    check("reset_err", 256'(err), 256'(0));
    check("reset_result", result, 256'(0));
    check("reset_tvalid", 256'(m_tvalid), 256'(0));
    check("reset_tlast", 256'(m_tlast), 256'(0));
    check("reset_tdata", 256'(m_tdata), 256'(0));
    check("reset_s_tready", 256'(s_tready), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal job: header words 1..20, hash A0..A7 with tlast on the 8th
    do_start(make_hdr(32'h0));
    send_phase(make_hdr(32'h0), 1'b0, 1'b0, -1, -1);
    recv_phase(8, 7, 1'b0, make_res(8), 1'b0);

    // Random backpressure, with slave-side junk offered while sending
    do_start(make_hdr(32'h100));
    send_phase(make_hdr(32'h100), 1'b1, 1'b1, -1, -1);
    recv_phase(8, 7, 1'b0, make_res(8), 1'b0);

    // Early tlast on the 5th word
    do_start(make_hdr(32'h200));
    send_phase(make_hdr(32'h200), 1'b0, 1'b0, -1, -1);
    recv_phase(5, 4, 1'b0, make_res(5), 1'b1);

    // Missing tlast: ninth word offered but must not be accepted
    do_start(make_hdr(32'h300));
    send_phase(make_hdr(32'h300), 1'b0, 1'b0, -1, -1);
    recv_phase(8, -1, 1'b1, make_res(8), 1'b1);

    // Start during SEND with another header is ignored
    do_start(make_hdr(32'h400));
    send_phase(make_hdr(32'h400), 1'b1, 1'b0, 3, -1);
    recv_phase(8, 7, 1'b0, make_res(8), 1'b0);

    // Asynchronous reset after seven beats, then a fresh job from word 0
    do_start(make_hdr(32'h500));
    send_phase(make_hdr(32'h500), 1'b0, 1'b0, -1, 7);
    @(negedge clk);
    check("midrst_result", result, 256'(0));
    check("midrst_err", 256'(err), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 256'(busy), 256'(0));
    do_start(make_hdr(32'h600));
    send_phase(make_hdr(32'h600), 1'b0, 1'b0, -1, -1);
    recv_phase(8, 7, 1'b0, make_res(8), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
